usr_rx_arb: RTL and testbench

//   Packet-atomic round-robin arbiter merging two user Rx AXI4-Stream flows into one

---
 rtl/usr_rx_arb.sv | 163 ++++++++++++++++
 tb/tb_usr_rx_arb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_rx_arb.sv
// Packet-atomic round-robin merge of two AXI4-Stream Rx flows into one registered stream.
// Grants are issued per packet; beats of different packets never interleave.
module usr_rx_arb #(
    parameter int CNT_W = 32,
    parameter int DW    = 64
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,

    input  logic [DW-1:0]     s0_axis_tdata,
    input  logic [DW/8-1:0]   s0_axis_tkeep,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,

    input  logic [DW-1:0]     s1_axis_tdata,
    input  logic [DW/8-1:0]   s1_axis_tkeep,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,

    output logic [DW-1:0]     m_axis_tdata,
    output logic [DW/8-1:0]   m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,

    input  logic              arb_en,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    localparam int KW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD0 = 2'd1,
        FWD1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;

    logic [DW-1:0]      data_q;
    logic [KW-1:0]      keep_q;
    logic               valid_q;
    logic               tlast_q;

    logic [1:0]         s_valid;
    logic [1:0]         s_ready;
    logic [1:0]         s_last;
    logic [DW-1:0]      s_data [2];
    logic [KW-1:0]      s_keep [2];
    logic [CNT_W-1:0]   cnt_out [2];

    logic               fwd_active;
    logic               fwd_port;
    logic               out_free;
    logic               accept;
    logic               eop;
    logic               grant_vld;
    logic               grant_port;

    assign s_valid   = {s1_axis_tvalid, s0_axis_tvalid};
    assign s_last    = {s1_axis_tlast,  s0_axis_tlast};
    assign s_data[0] = s0_axis_tdata;
    assign s_data[1] = s1_axis_tdata;
    assign s_keep[0] = s0_axis_tkeep;
    assign s_keep[1] = s1_axis_tkeep;

    assign s0_axis_tready = s_ready[0];
    assign s1_axis_tready = s_ready[1];

    assign fwd_active = (state_q != IDLE);
    assign fwd_port   = (state_q == FWD1);
    // The output register can take a beat when empty or when it drains this cycle.
    assign out_free   = ~valid_q | m_axis_tready;
    assign accept     = |(s_valid & s_ready);
    assign eop        = accept & s_last[fwd_port];

    // Both requesting: the port that did not win last time; otherwise the sole requester.
    assign grant_vld  = arb_en & (|s_valid);
    assign grant_port = (&s_valid) ? ~last_grant_q : s_valid[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [CNT_W-1:0] cnt_q;

            assign s_ready[gi] = fwd_active & (fwd_port == 1'(gi)) & out_free;

            always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
                if (!m_axis_aresetn) begin
                    cnt_q <= '0;
                end else if (eop && (fwd_port == 1'(gi))) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign cnt_out[gi] = cnt_q;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d      = grant_port ? FWD1 : FWD0;
                    last_grant_d = grant_port;
                end
            end
            FWD0, FWD1: begin
                // Re-arbitrate on the tlast beat so the next packet follows without a bubble.
                if (eop) begin
                    if (grant_vld) begin
                        state_d      = grant_port ? FWD1 : FWD0;
                        last_grant_d = grant_port;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            data_q  <= '0;
            keep_q  <= '0;
            tlast_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept) begin
            data_q  <= s_data[fwd_port];
            keep_q  <= s_keep[fwd_port];
            tlast_q <= s_last[fwd_port];
            valid_q <= 1'b1;
        end else if (m_axis_tready) begin
            valid_q <= 1'b0;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = valid_q;
    assign busy          = fwd_active;
    assign pkt_cnt0      = cnt_out[0];
    assign pkt_cnt1      = cnt_out[1];

endmodule

// File: tb/tb_usr_rx_arb.sv
// Bench for usr_rx_arb: a packet-level model predicts every output each cycle,
// and directed scenarios pin timing, ordering and counter values with literal expectations.
module tb_usr_rx_arb;

    localparam int DW       = 64;
    localparam int KW       = DW / 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MASK = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     s0_tdata, s1_tdata, m_tdata;
    logic [KW-1:0]     s0_tkeep, s1_tkeep, m_tkeep;
    logic              s0_tvalid, s1_tvalid, m_tvalid;
    logic              s0_tlast, s1_tlast, m_tlast;
    logic              s0_tready, s1_tready, m_tready;
    logic              arb_en, busy;
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

    always #5 clk = ~clk;

    usr_rx_arb #(.CNT_W(CNT_W), .DW(DW)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tkeep  (s0_tkeep),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tlast  (s0_tlast),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tkeep  (s1_tkeep),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tlast  (s1_tlast),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .arb_en         (arb_en),
        .busy           (busy),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        int    cyc;
        beat_t b;
    } log_t;

    beat_t q0[$];
    beat_t q1[$];
    log_t  out_log[$];

    // Model: which port currently owns the output, who won last, what sits in the output slot.
    int    owner;
    int    lastg;
    beat_t mreg;
    bit    mv;
    int    cnt0, cnt1;
    int    cyc;
    int    n_tests;
    int    n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        lastg = 1;
        mreg  = '0;
        mv    = 1'b0;
        cnt0  = 0;
        cnt1  = 0;
    endtask

    function automatic int pick(input bit v0, input bit v1);
        if (!arb_en)   return -1;
        if (v0 && v1)  return 1 - lastg;
        if (v0)        return 0;
        if (v1)        return 1;
        return -1;
    endfunction

    task automatic model_step();
        bit    v0, v1, acc;
        int    g, po;
        beat_t b;
        v0  = s0_tvalid;
        v1  = s1_tvalid;
        po  = owner;
        acc = 1'b0;
        b   = '0;
        if (po == 0) acc = v0 && (!mv || m_tready);
        if (po == 1) acc = v1 && (!mv || m_tready);
        if (acc) b = (po == 1) ? q1[0] : q0[0];
        if (po < 0) begin
            g = pick(v0, v1);
            if (g >= 0) begin
                owner = g;
                lastg = g;
            end
        end else if (acc && b.l) begin
            if (po == 0) cnt0 = (cnt0 + 1) & CNT_MASK;
            else         cnt1 = (cnt1 + 1) & CNT_MASK;
            g     = pick(v0, v1);
            owner = g;
            if (g >= 0) lastg = g;
        end
        if (acc) begin
            mreg = b;
            mv   = 1'b1;
            if (po == 1) void'(q1.pop_front());
            else         void'(q0.pop_front());
        end else if (m_tready) begin
            mv = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        beat_t b0, b1;
        b0 = (q0.size() > 0) ? q0[0] : '0;
        b1 = (q1.size() > 0) ? q1[0] : '0;
        s0_tvalid = (q0.size() > 0);
        s0_tdata  = b0.d;
        s0_tkeep  = b0.k;
        s0_tlast  = b0.l;
        s1_tvalid = (q1.size() > 0);
        s1_tdata  = b1.d;
        s1_tkeep  = b1.k;
        s1_tlast  = b1.l;
    endtask

    task automatic compare_cycle();
        chk("m_tvalid",  m_tvalid, mv);
        chk("m_tdata",   m_tdata, mreg.d);
        chk("m_tkeep",   m_tkeep, mreg.k);
        chk("m_tlast",   m_tlast, mreg.l);
        chk("busy",      busy, owner >= 0);
        chk("s0_tready", s0_tready, (owner == 0) && (!mv || m_tready));
        chk("s1_tready", s1_tready, (owner == 1) && (!mv || m_tready));
        chk("pkt_cnt0",  pkt_cnt0, cnt0);
        chk("pkt_cnt1",  pkt_cnt1, cnt1);
    endtask

    // One clock: present inputs, log any output beat handed off at the coming edge,
    // advance the model at the edge, compare at the falling edge.
    task automatic tick();
        log_t e;
        drive_inputs();
        if (rst_n && m_tvalid && m_tready) begin
            e.cyc = cyc;
            e.b   = {m_tdata, m_tkeep, m_tlast};
            out_log.push_back(e);
            $display("[TB] cyc %0d beat data=%0h keep=%0h last=%0b", cyc, m_tdata, m_tkeep, m_tlast);
        end
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic add_pkt(input int port, input logic [DW-1:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = base + DW'(i);
            b.k = (i == n - 1) ? 8'h0F : 8'hFF;
            b.l = (i == n - 1);
            if (port == 0) q0.push_back(b);
            else           q1.push_back(b);
        end
    endtask

    task automatic run_until(input int n, input int budget);
        int g;
        g = 0;
        while (out_log.size() < n && g < budget) begin
            tick();
            g++;
        end
        chk("beats_within_budget", out_log.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        model_reset();
        drive_inputs();
        #1;
        chk("rst_m_tvalid",  m_tvalid, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_pkt_cnt0",  pkt_cnt0, 0);
        chk("rst_pkt_cnt1",  pkt_cnt1, 0);
        chk("rst_busy",      busy, 0);
        compare_cycle();
        repeat (2) tick();
        rst_n = 1'b1;
        out_log.delete();
    endtask

    initial begin
        int start, c0;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        m_tready = 1'b1;
        arb_en   = 1'b1;
        model_reset();
        drive_inputs();
        repeat (2) tick();
        rst_n = 1'b1;

        // Port 0 alone, 3 beats: output on cycles 2,3,4 after tvalid.
        out_log.delete();
        add_pkt(0, 64'hA0, 3);
        start = cyc;
        run_until(3, 40);
        repeat (3) tick();
        if (out_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t1_data",    out_log[i].b.d, 64'hA0 + 64'(i));
                chk("t1_latency", out_log[i].cyc - start, 2 + i);
                chk("t1_last",    out_log[i].b.l, i == 2);
            end
        end
        chk("t1_cnt0", pkt_cnt0, 1);
        chk("t1_cnt1", pkt_cnt1, 0);

        // Reset mid-traffic with a full output register.
        add_pkt(0, 64'h10, 4);
        add_pkt(1, 64'h20, 4);
        repeat (3) tick();
        chk("pre_rst_valid", m_tvalid, 1);
        do_reset();

        // Both ports valid from reset: p0 packet then p1 packet, back to back.
        add_pkt(0, 64'hB0, 4);
        add_pkt(1, 64'hC0, 4);
        run_until(8, 60);
        repeat (3) tick();
        if (out_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t2_data", out_log[i].b.d, (i < 4) ? 64'hB0 + 64'(i) : 64'hC0 + 64'(i - 4));
                chk("t2_nogap", out_log[i].cyc - out_log[0].cyc, i);
            end
        end
        chk("t2_cnt0", pkt_cnt0, 1);
        chk("t2_cnt1", pkt_cnt1, 1);

        // Backpressure for 5 cycles after beat 2 of 6.
        do_reset();
        add_pkt(0, 64'hD0, 6);
        run_until(2, 40);
        m_tready = 1'b0;
        repeat (5) begin
            tick();
            chk("t3_hold_data",  m_tdata, 64'hD2);
            chk("t3_hold_keep",  m_tkeep, 8'hFF);
            chk("t3_hold_valid", m_tvalid, 1);
            chk("t3_s0_blocked", s0_tready, 0);
        end
        m_tready = 1'b1;
        run_until(6, 40);
        if (out_log.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("t3_order", out_log[i].b.d, 64'hD0 + 64'(i));
        end

        // arb_en drops mid-packet with port 1 waiting.
        do_reset();
        add_pkt(0, 64'hE0, 4);
        add_pkt(1, 64'hF0, 2);
        run_until(1, 40);
        arb_en = 1'b0;
        repeat (8) tick();
        chk("t4_idle",   busy, 0);
        chk("t4_nbeats", out_log.size(), 4);
        if (out_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t4_p0_data", out_log[i].b.d, 64'hE0 + 64'(i));
        end
        chk("t4_s1_held", s1_tready, 0);
        c0 = cyc;
        arb_en = 1'b1;
        run_until(6, 40);
        if (out_log.size() == 6) begin
            chk("t4_f0",     out_log[4].b.d, 64'hF0);
            chk("t4_bubble", out_log[4].cyc - c0, 2);
            chk("t4_f1",     out_log[5].b.d, 64'hF1);
        end

        // 17 single-beat packets on port 1 wrap the 4-bit counter to 1.
        do_reset();
        for (int i = 0; i < 17; i++) add_pkt(1, 64'h100 + 64'(i), 1);
        run_until(17, 100);
        repeat (3) tick();
        if (out_log.size() == 17) chk("t5_sustained", out_log[16].cyc - out_log[0].cyc, 16);
        chk("t5_cnt1", pkt_cnt1, 1);
        chk("t5_cnt0", pkt_cnt0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
